// File: rtl/disp_writer_if.sv
// disp_writer_if: request handshake plus display-bus outputs of disp_writer.
// The slave modport is the writer; the master modport is the requesting host.
interface disp_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_digits;
  logic [3:0]  req_dp;
  logic [3:0]  req_mask;
  logic [7:0]  ctrl;
  logic        busy;
  logic        done;

  modport master (
    output req_valid,
    output req_digits,
    output req_dp,
    output req_mask,
    input  req_ready,
    input  ctrl,
    input  busy,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_digits,
    input  req_dp,
    input  req_mask,
    output req_ready,
    output ctrl,
    output busy,
    output done
  );
endinterface

// File: rtl/disp_writer.sv
// disp_writer: serialises masked 4-digit updates into strobed writes on the 8-bit ctrl bus.
// Defining DISP_WRITER_BCD_EN adds a 14-cycle binary-to-BCD front end (CONV state).
module disp_writer #(
  parameter int unsigned STB_LEN = 4,
  parameter int unsigned GAP_LEN = 2
) (
  input logic          clk,
  input logic          rst,
  disp_writer_if.slave io_bus
);

`ifdef DISP_WRITER_BCD_EN
  typedef enum logic [2:0] {StIdle, StConv, StSetup, StStrobe, StGap, StDone} state_e;
  localparam logic [7:0] CONV_LAST = 8'd13;
`else
  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StGap, StDone} state_e;
`endif
  localparam logic [7:0] STB_LAST = 8'(STB_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);

  state_e      r_state;
  state_e      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic [1:0]  r_slot;
  logic [3:0]  r_mask;
  logic [3:0]  r_dp;
  logic [15:0] r_digits;
  logic [7:0]  r_ctrl;
  logic [7:0]  w_ctrl_next;
  logic        r_busy;
  logic        r_done;
  logic        r_ready;
  logic        w_busy_next;
  logic        w_done_next;
  logic        w_ready_next;
  logic        w_accept;
  logic [3:0]  w_src_mask;
  logic [2:0]  w_search_from;
  logic        w_slot_found;
  logic [1:0]  w_slot_sel;
  logic [3:0]  w_nibble;

  assign w_accept      = io_bus.req_valid && r_ready;
  assign w_src_mask    = w_accept ? io_bus.req_mask : r_mask;
  assign w_search_from = (r_state == StGap) ? ({1'b0, r_slot} + 3'd1) : 3'd0;
  assign w_nibble      = r_digits[{r_slot, 2'b00} +: 4];

  // Lowest enabled slot at or above w_search_from; a 3-bit start of 4 means none left.
  always_comb begin
    w_slot_found = 1'b0;
    w_slot_sel   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_src_mask[i] && (3'(i) >= w_search_from)) begin
        w_slot_found = 1'b1;
        w_slot_sel   = 2'(i);
      end
    end
  end

`ifdef DISP_WRITER_BCD_EN
  logic [13:0] r_bin;
  logic [13:0] w_bin_sat;
  logic [15:0] w_bcd_adj;
  logic [15:0] w_bcd_shift;

  assign w_bin_sat = (io_bus.req_digits > 16'd9999) ? 14'd9999 : io_bus.req_digits[13:0];

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  always_comb begin
    w_bcd_adj = r_digits;
    for (int i = 0; i < 4; i++) begin
      if (r_digits[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_digits[4*i +: 4] + 4'd3;
      end
    end
    w_bcd_shift = (w_bcd_adj << 1) | {15'd0, r_bin[13]};
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_ctrl  <= 8'h80;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ctrl  <= w_ctrl_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_ready <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
`ifdef DISP_WRITER_BCD_EN
          w_state_next = StConv;
`else
          w_state_next = w_slot_found ? StSetup : StDone;
`endif
        end else begin
          w_state_next = StIdle;
        end
      end
`ifdef DISP_WRITER_BCD_EN
      StConv: begin
        if (r_cnt == CONV_LAST) w_state_next = w_slot_found ? StSetup : StDone;
      end
`endif
      StSetup:  w_state_next = StStrobe;
      StStrobe: if (r_cnt == STB_LAST) w_state_next = StGap;
      StGap: begin
        if (r_cnt == GAP_LAST) w_state_next = w_slot_found ? StSetup : StDone;
      end
      default:  w_state_next = StIdle;
    endcase
  end

  // Outputs lag the state by one register stage; ctrl[6:0] is frozen from SETUP onwards.
  always_comb begin
    w_ctrl_next  = 8'h80;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    w_ready_next = 1'b0;
    unique case (r_state)
      StIdle: w_ready_next = !w_accept;
`ifdef DISP_WRITER_BCD_EN
      StConv: w_busy_next = 1'b1;
`endif
      StSetup: begin
        w_busy_next = 1'b1;
        w_ctrl_next = {1'b1, r_slot, r_dp[r_slot], w_nibble};
      end
      StStrobe: begin
        w_busy_next = 1'b1;
        w_ctrl_next = {1'b0, r_ctrl[6:0]};
      end
      StGap: begin
        w_busy_next = 1'b1;
        w_ctrl_next = {1'b1, r_ctrl[6:0]};
      end
      StDone: begin
        w_done_next  = 1'b1;
        w_ready_next = !w_accept;
      end
      default: ;
    endcase
  end

  assign w_cnt_next = (w_state_next != r_state) ? 8'd0 : (r_cnt + 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 8'd0;
      r_slot   <= 2'd0;
      r_mask   <= 4'd0;
      r_dp     <= 4'd0;
      r_digits <= 16'd0;
`ifdef DISP_WRITER_BCD_EN
      r_bin    <= 14'd0;
`endif
    end else begin
      r_cnt <= w_cnt_next;
      if (w_state_next == StSetup) r_slot <= w_slot_sel;
      if (w_accept) begin
        r_mask <= io_bus.req_mask;
        r_dp   <= io_bus.req_dp;
`ifdef DISP_WRITER_BCD_EN
        r_digits <= 16'd0;
        r_bin    <= w_bin_sat;
`else
        r_digits <= io_bus.req_digits;
`endif
      end
`ifdef DISP_WRITER_BCD_EN
      else if (r_state == StConv) begin
        r_digits <= w_bcd_shift;
        r_bin    <= r_bin << 1;
      end
`endif
    end
  end

  assign io_bus.ctrl      = r_ctrl;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.req_ready = r_ready;

endmodule

// File: doc/disp_writer.md
# disp_writer

Host-side initiator for the 8-bit digit-write control bus consumed by the 4-digit multiplexed LED display driver. Accepts a 4-digit update request over a valid/ready handshake. Serialises it into per-digit write transactions on `ctrl`: data set up, strobe pulsed low, data held. Sits between the application logic (counters, UART command decoder) and the display driver.

## Interface
Parameters:
- `STB_LEN`, 4: cycles `ctrl[7]` is held low per write; legal range 1..255.
- `GAP_LEN`, 2: cycles `ctrl[7]` is held high, with `ctrl[6:0]` unchanged, after each strobe; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_digits`  in  16  slot i digit in `[4i+3:4i]`; slot 0 is the low nibble.
- `req_dp`  in  4  bit i is the attribute/decimal-point flag for slot i.
- `req_mask`  in  4  bit i set means slot i is written.
- `ctrl`  out  8  display bus: `{strobe_n, slot[1:0], dp, digit[3:0]}`.
- `busy`  out  1  high from acceptance until `done`.
- `done`  out  1  single-cycle pulse when a request completes.

## Operation
- Handshake:
  - Transfer when `req_valid && req_ready` at a rising edge; `req_digits`, `req_dp` and `req_mask` are captured then.
  - Inputs are ignored while `busy`.
- States: IDLE → (CONV, `DISP_WRITER_BCD_EN` only) → SETUP → STROBE → GAP → (SETUP for next slot | DONE) → IDLE.
- Slot order: ascending 0..3; slots whose mask bit is 0 are skipped and produce no bus activity.
- SETUP, 1 cycle: `ctrl[6:0]` = `{slot, dp[slot], digit[slot]}`; `ctrl[7]`=1.
- STROBE, `STB_LEN` cycles: `ctrl[7]`=0; `ctrl[6:0]` stable.
- GAP, `GAP_LEN` cycles: `ctrl[7]`=1; `ctrl[6:0]` held from SETUP.
- DONE: `done`=1 for one cycle, `busy`=0 and `req_ready`=1 in the same cycle; next state IDLE.
- Mask of 4'b0000: accepted; goes straight to DONE with no strobe.
- All outputs are registered; `ctrl[6:0]` never changes while `ctrl[7]`=0. The display latches on the falling edge of `ctrl[7]`, so this guarantees a glitch-free capture.
- Idle bus value: `ctrl` = 8'h80.

## Timing
- Edge 0 is the acceptance edge. For the n-th written slot (n = 0..3), with P = 1+`STB_LEN`+`GAP_LEN`:
  - SETUP begins at edge 1+nP.
  - `ctrl[7]` falls at edge 2+nP.
  - `ctrl[7]` rises at edge 2+`STB_LEN`+nP.
- `done` asserts at edge 1+kP, where k is the number of written slots.
- Defaults with a full mask: P=7; strobes fall at edges 2, 9, 16, 23; `done` at edge 29.
- Back-to-back: `req_ready` rises with `done`, so a held `req_valid` is accepted at the following edge. The first new SETUP therefore starts 2 cycles after `done`.
- Reset values:
  - `ctrl`=8'h80, `busy`=0, `done`=0.
  - `req_ready`=0 while `rst`=1; 1 from the first edge after release.
  - FSM in IDLE.
- Reset mid-operation: outputs go to reset values immediately (asynchronously). An in-progress strobe is released without a new falling edge, and the remaining slots are discarded.
- Width rules: slot counter is 2 bits; no wrap beyond slot 3.

## Configuration
- `DISP_WRITER_BCD_EN`:
  - Defined: `req_digits[13:0]` is an unsigned binary value. CONV runs a sequential double-dabble for exactly 14 cycles, then SETUP starts, so every edge in Timing shifts by +14.
    - Values above 9999 (including `req_digits[15:14]` ≠ 0) saturate to 9999.
    - BCD digit i drives slot i; slot 0 is the ones digit.
  - Undefined: `req_digits` is used as four raw nibbles. There is no CONV state and no conversion logic.

## Test plan
- Single slot: mask 4'b0100, digits 16'h1234, dp 0.
  - `ctrl`=8'hC2 at edge 1, 8'h42 at edges 2–5, 8'hC2 at edges 6–7.
  - `done` at edge 8; no other strobes.
- Full update, defaults: mask 4'hF, digits 16'h1234, dp 4'b0001.
  - Strobe bytes are 8'h14, 8'h23, 8'h42, 8'h61, falling at edges 2/9/16/23.
  - `done` at edge 29; `busy` is high for edges 1–28.
- Mask 4'b0000: `done` at edge 1; `ctrl` stays 8'h80 throughout.
- Back-to-back: `req_valid` held high for two requests.
  - Second acceptance at the edge after the first `done`.
  - Changes to `req_*` during `busy` have no effect on the bus.
- Reset mid-strobe: assert `rst` at edge 10 of a full update.
  - `ctrl`=8'h80, `busy`=0 immediately.
  - After release, `req_ready`=1 and a new request runs normally.
- With `DISP_WRITER_BCD_EN`:
  - `req_digits`=16'd1234 (mask 4'hF, dp 0) gives strobe bytes 8'h04, 8'h23, 8'h42, 8'h61, the first strobe at edge 16.
  - 16'd12000 gives digits 9,9,9,9.
